// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module  : imm_gen_pipe
// Brief   : Pipelined RISC-V immediate generator. Valid/ready in and out,
//           a 2-entry skid buffer, and a saturating illegal-opcode counter.
// Revision: 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic             zext_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] ill_cnt_o,
    input  logic             cnt_clr_i
);

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic            sbit;
    logic [31:0]     dec_imm32;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic            dec_hi;
    logic [XLEN-1:0] dec_imm;

    // zext forces the replicated sign bit to zero for every signed format
    assign sbit = instr_i[31] & ~zext_i;

    always_comb begin
        dec_imm32 = 32'd0;
        dec_fmt   = FMT_ILL;
        dec_ill   = 1'b1;
        case (instr_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                dec_imm32 = {{20{sbit}}, instr_i[31:20]};
                dec_fmt   = FMT_I;
                dec_ill   = 1'b0;
            end
            OP_STORE: begin
                dec_imm32 = {{20{sbit}}, instr_i[31:25], instr_i[11:7]};
                dec_fmt   = FMT_S;
                dec_ill   = 1'b0;
            end
            OP_BRANCH: begin
                dec_imm32 = {{19{sbit}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
                dec_fmt   = FMT_B;
                dec_ill   = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm32 = {instr_i[31:12], 12'd0};
                dec_fmt   = FMT_U;
                dec_ill   = 1'b0;
            end
            OP_JAL: begin
                dec_imm32 = {{11{sbit}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
                dec_fmt   = FMT_J;
                dec_ill   = 1'b0;
            end
            default: begin
                dec_imm32 = 32'd0;
                dec_fmt   = FMT_ILL;
                dec_ill   = 1'b1;
            end
        endcase
    end

    assign dec_hi = dec_imm32[31] & ~zext_i;

    generate
        if (XLEN > 32) begin : g_wide
            assign dec_imm = {{(XLEN-32){dec_hi}}, dec_imm32};
        end else begin : g_narrow
            logic unused_dec_bits;
            assign dec_imm         = dec_imm32[XLEN-1:0];
            assign unused_dec_bits = ^{dec_imm32, dec_hi};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Two-entry skid buffer: output register plus one skid register
    // ------------------------------------------------------------------
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic [2:0]      out_fmt_q,   out_fmt_d;
    logic            out_ill_q,   out_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic [2:0]      skid_fmt_q,   skid_fmt_d;
    logic            skid_ill_q,   skid_ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic drain;

    assign accept = in_valid_i & ~skid_valid_q;
    assign drain  = out_valid_q & out_ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;

        if (!out_valid_q || drain) begin
            // Output slot frees up: oldest pending entry takes it
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_ill_d   = dec_ill;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (accept && dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= 3'd0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= 3'd0;
            skid_ill_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign imm_o       = out_imm_q;
    assign fmt_o       = out_fmt_q;
    assign illegal_o   = out_ill_q;
    assign ill_cnt_o   = cnt_q;

endmodule
`default_nettype wire
